bad_point_stream_matcher: RTL

// Holds a host-written list of manually flagged bad-pixel coordinates in on-chip RAM and matches it against the live pixel stream.

---
 rtl/bad_point_stream_matcher.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bad_point_stream_matcher.sv
// bad_point_stream_matcher
//   Matches a host-written list of bad-pixel coordinates (raster sorted)
//   against the live pixel stream and flags each listed pixel one cycle
//   after it arrives.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   enable                level; matcher runs while high
//   cfg_width/height      active frame size
//   bad_point_num         number of valid list entries, sampled in LOAD
//   wen_lut/waddr_lut/wdata_lut  list write port ([31:16]=x, [15:0]=y)
//   sof, pix_valid        input pixel stream
//   out_valid/out_bad/out_x/out_y  registered per-pixel result
//   frame_done            pulse with the result of the last frame pixel
//   miss_cnt              entries not hit in the last frame
//   err_sticky            [0] write while busy, [1] sof outside ARMED
module bad_point_stream_matcher #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_NUM = 128,
  parameter int BAD_POINT_BIT = $clog2(BAD_POINT_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH_BITS-1:0]    cfg_width,
  input  logic [HEIGHT_BITS-1:0]   cfg_height,
  input  logic [BAD_POINT_BIT:0]   bad_point_num,
  input  logic                     wen_lut,
  input  logic [BAD_POINT_BIT-1:0] waddr_lut,
  input  logic [31:0]              wdata_lut,
  input  logic                     sof,
  input  logic                     pix_valid,
  output logic                     out_valid,
  output logic                     out_bad,
  output logic [WIDTH_BITS-1:0]    out_x,
  output logic [HEIGHT_BITS-1:0]   out_y,
  output logic                     frame_done,
  output logic [BAD_POINT_BIT:0]   miss_cnt,
  output logic [1:0]               err_sticky
);

  localparam int KW = WIDTH_BITS + HEIGHT_BITS;
  localparam int CW = BAD_POINT_BIT + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic [KW-1:0]            r_mem [BAD_POINT_NUM];
  logic [KW-1:0]            r_ram_q;
  logic [KW-1:0]            r_cur, r_nxt;
  logic [BAD_POINT_BIT-1:0] r_raddr, w_raddr;
  logic [1:0]               r_ld;
  logic [CW-1:0]            r_n, r_idx, r_hits;
  logic [WIDTH_BITS-1:0]    r_x;
  logic [HEIGHT_BITS-1:0]   r_y;

  logic [KW-1:0] w_wkey, w_pkey;
  logic          w_wr_ok, w_wr_bad, w_reload, w_sof, w_err_sof, w_start;
  logic          w_beat, w_cur_vld, w_hit, w_skip, w_adv, w_eol, w_last;
  logic [CW-1:0] w_n_clamp;
  logic          w_unused;

  // Keys are raster ordered {y,x} so a plain unsigned compare gives order.
  assign w_wkey    = {wdata_lut[HEIGHT_BITS-1:0], wdata_lut[16 +: WIDTH_BITS]};
  assign w_unused  = ^{wdata_lut[31:16+WIDTH_BITS], wdata_lut[15:HEIGHT_BITS]};
  assign w_pkey    = {r_y, r_x};
  assign w_n_clamp = (bad_point_num > CW'(BAD_POINT_NUM)) ? CW'(BAD_POINT_NUM)
                                                          : bad_point_num;

  assign w_wr_ok   = wen_lut && (r_state == S_IDLE || r_state == S_ARMED);
  assign w_wr_bad  = wen_lut && !w_wr_ok;
  // Entries 0/1 already sit in cur/nxt, so rewriting them needs a reload.
  assign w_reload  = (r_state == S_ARMED) && w_wr_ok && (waddr_lut < BAD_POINT_BIT'(2));
  assign w_sof     = sof && pix_valid;
  assign w_err_sof = w_sof && (r_state != S_ARMED);
  assign w_start   = (r_state == S_ARMED) && w_sof && !w_reload && enable;

  // Counters are 0 in ARMED, so the sof beat is pixel (0,0).
  assign w_beat    = w_start || ((r_state == S_ACTIVE) && pix_valid);
  assign w_cur_vld = r_idx < r_n;
  assign w_hit     = w_beat && w_cur_vld && (w_pkey == r_cur);
  assign w_skip    = w_beat && w_cur_vld && (w_pkey > r_cur);
  assign w_adv     = w_hit || w_skip;
  assign w_eol     = r_x == cfg_width - 1'b1;
  assign w_last    = w_beat && w_eol && (r_y == cfg_height - 1'b1);

  // RAM read address is steered combinationally so r_ram_q always holds the
  // entry after nxt, even when the pointer advances every cycle.
  always_comb begin
    w_raddr = r_raddr;
    if (r_state == S_LOAD) w_raddr = BAD_POINT_BIT'(r_ld);
    else if (w_adv)        w_raddr = r_raddr + 1'b1;
  end

  // List RAM; the write-to-read bypass keeps a write landing on the entry
  // being fetched from leaving stale data behind nxt.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[waddr_lut] <= w_wkey;
    r_ram_q <= (w_wr_ok && waddr_lut == w_raddr) ? w_wkey : r_mem[w_raddr];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_LOAD;
      S_LOAD:   if (r_ld == 2'd2) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (w_reload)     w_state_nxt = S_LOAD;
        else if (!enable) w_state_nxt = S_IDLE;
        else if (w_sof)   w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: if (w_last) w_state_nxt = enable ? S_LOAD : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ld       <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_hits     <= '0;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_raddr    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      out_valid  <= 1'b0;
      out_bad    <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
      miss_cnt   <= '0;
      err_sticky <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ld    <= (r_state == S_LOAD) ? r_ld + 1'b1 : 2'd0;

      if (r_state == S_LOAD) begin
        r_idx  <= '0;
        r_hits <= '0;
        r_x    <= '0;
        r_y    <= '0;
        case (r_ld)
          2'd0:    r_n   <= w_n_clamp;
          2'd1:    r_cur <= r_ram_q;
          default: begin
            r_nxt   <= r_ram_q;
            r_raddr <= BAD_POINT_BIT'(2);
          end
        endcase
      end

      if (w_adv) begin
        r_cur   <= r_nxt;
        r_nxt   <= r_ram_q;
        r_raddr <= r_raddr + 1'b1;
        r_idx   <= r_idx + 1'b1;
      end
      if (w_hit) r_hits <= r_hits + 1'b1;

      if (w_beat) begin
        if (w_last) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_eol) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      out_valid  <= pix_valid;
      out_bad    <= w_hit;
      out_x      <= r_x;
      out_y      <= r_y;
      frame_done <= w_last;
      // Every consumed entry is a hit or a skip and the rest are misses, so
      // misses = N - hits; this is bounded by N by construction.
      if (w_last) miss_cnt <= r_n - (r_hits + CW'(w_hit));
      err_sticky <= err_sticky | {w_err_sof, w_wr_bad};
    end
  end

endmodule
